// File: rtl/cam_capture_pkg.sv
// cam_capture_pkg: shared image defaults, RGB332 field positions, colour thresholds and capture FSM states
package cam_capture_pkg;
  localparam int IMG_W_DEF = 176;
  localparam int IMG_H_DEF = 144;
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;
  localparam logic [2:0] RED_R_MIN  = 3'd5;
  localparam logic [1:0] RED_B_MAX  = 2'd1;
  localparam logic [1:0] BLUE_B_MIN = 2'd2;
  localparam logic [2:0] BLUE_R_MAX = 3'd2;
  typedef enum logic [1:0] {WAIT_VS = 2'd0, BLANK = 2'd1, ACTIVE = 2'd2} state_e;
endpackage

// File: rtl/cam_color_classify.sv
// cam_color_classify: combinational RGB332 -> {is_red, is_blue} treasure-colour classifier
//   pix_i     : RGB332 pixel {R[2:0],G[2:0],B[1:0]}
//   is_red_o  : R >= RED_R_MIN and B <= RED_B_MAX
//   is_blue_o : B >= BLUE_B_MIN and R <= BLUE_R_MAX
module cam_color_classify
  import cam_capture_pkg::*;
(
  input  logic [7:0] pix_i,
  output logic       is_red_o,
  output logic       is_blue_o
);
  logic [2:0] r;
  logic [1:0] b;
  logic       unused_g;
  assign r         = pix_i[R_MSB:R_LSB];
  assign b         = pix_i[B_MSB:B_LSB];
  assign unused_g  = ^pix_i[G_MSB:G_LSB];
  assign is_red_o  = (r >= RED_R_MIN) && (b <= RED_B_MAX);
  assign is_blue_o = (b >= BLUE_B_MIN) && (r <= BLUE_R_MAX);
endmodule

// File: rtl/cam_capture.sv
// cam_capture: OV7670 RGB565 stream -> RGB332 frame-buffer writes plus per-frame red/blue pixel counts
//   CLOCK/RESET          : pixel clock, synchronous active-high reset
//   CAM_VSYNC/HREF/DATA  : camera framing and byte stream
//   W_EN/W_ADDR/W_DATA   : registered frame-buffer write port (addr = y*IMG_W + x)
//   FRAME_DONE           : one-cycle pulse at end of a captured frame
//   RED_COUNT/BLUE_COUNT : colour counts of the last complete frame
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              CAM_VSYNC,
  input  logic              CAM_HREF,
  input  logic [7:0]        CAM_DATA,
  output logic              W_EN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              FRAME_DONE,
  output logic [CNT_W-1:0]  RED_COUNT,
  output logic [CNT_W-1:0]  BLUE_COUNT
);
  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam logic [XW-1:0]     X_END    = XW'(IMG_W);
  localparam logic [YW-1:0]     Y_END    = YW'(IMG_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  state_e            state_q, state_d;
  logic              vs_q, href_q, ph_q, ph_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [7:0]        hi_q, hi_d, data_q, data_d, pix;
  logic              wen_q, wen_d, done_q, done_d;
  logic              wr, is_red, is_blue, vs_rise;
  logic [CNT_W-1:0]  red_q, red_d, blue_q, blue_d, red_nx, blue_nx;
  logic [CNT_W-1:0]  red_cnt_q, red_cnt_d, blue_cnt_q, blue_cnt_d;

  cam_color_classify u_classify (
    .pix_i    (pix),
    .is_red_o (is_red),
    .is_blue_o(is_blue)
  );

  assign pix     = {hi_q[7:5], hi_q[2:0], CAM_DATA[4:3]};
  assign vs_rise = CAM_VSYNC && !vs_q;
  // Second byte of an in-window pixel; out-of-window pixels are neither written nor counted.
  assign wr      = (state_q == ACTIVE) && CAM_HREF && ph_q && (x_q < X_END) && (y_q < Y_END);
  assign red_nx  = red_q + CNT_W'(wr && is_red && (red_q != '1));
  assign blue_nx = blue_q + CNT_W'(wr && is_blue && (blue_q != '1));

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    ph_d       = ph_q;
    hi_d       = hi_q;
    base_d     = base_q;
    red_d      = red_q;
    blue_d     = blue_q;
    wen_d      = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = 1'b0;
    red_cnt_d  = red_cnt_q;
    blue_cnt_d = blue_cnt_q;
    case (state_q)
      WAIT_VS: state_d = CAM_VSYNC ? BLANK : WAIT_VS;
      BLANK: begin
        if (vs_q && !CAM_VSYNC) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
          ph_d    = 1'b0;
          base_d  = '0;
          red_d   = '0;
          blue_d  = '0;
        end
      end
      ACTIVE: begin
        if (CAM_HREF) begin
          ph_d = !ph_q;
          hi_d = ph_q ? hi_q : CAM_DATA;
          x_d  = (ph_q && (x_q != X_END)) ? x_q + 1'b1 : x_q;
          if (wr) begin
            wen_d  = 1'b1;
            addr_d = base_q + ADDR_W'(x_q);
            data_d = pix;
            red_d  = red_nx;
            blue_d = blue_nx;
          end
        end else if (href_q) begin
          x_d    = '0;
          ph_d   = 1'b0;
          y_d    = (y_q != Y_END) ? y_q + 1'b1 : y_q;
          base_d = (y_q != Y_END) ? base_q + ROW_STEP : base_q;
        end
        // A pixel completing on the same edge is already folded into red_nx/blue_nx.
        if (vs_rise) begin
          state_d    = BLANK;
          done_d     = 1'b1;
          red_cnt_d  = red_nx;
          blue_cnt_d = blue_nx;
        end
      end
      default: state_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= WAIT_VS;
      vs_q       <= 1'b0;
      href_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      ph_q       <= 1'b0;
      hi_q       <= '0;
      base_q     <= '0;
      red_q      <= '0;
      blue_q     <= '0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      red_cnt_q  <= '0;
      blue_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      vs_q       <= CAM_VSYNC;
      href_q     <= CAM_HREF;
      x_q        <= x_d;
      y_q        <= y_d;
      ph_q       <= ph_d;
      hi_q       <= hi_d;
      base_q     <= base_d;
      red_q      <= red_d;
      blue_q     <= blue_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      red_cnt_q  <= red_cnt_d;
      blue_cnt_q <= blue_cnt_d;
    end
  end

  assign W_EN       = wen_q;
  assign W_ADDR     = addr_q;
  assign W_DATA     = data_q;
  assign FRAME_DONE = done_q;
  assign RED_COUNT  = red_cnt_q;
  assign BLUE_COUNT = blue_cnt_q;
endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: random and directed camera streams checked against a frame-level reference model
module tb_cam_capture;
  localparam int IMG_W  = 176;
  localparam int IMG_H  = 144;
  localparam int ADDR_W = 15;
  localparam int CNT_W  = 16;

  logic              CLOCK = 1'b0;
  logic              RESET, CAM_VSYNC, CAM_HREF;
  logic [7:0]        CAM_DATA;
  logic              W_EN, FRAME_DONE;
  logic [ADDR_W-1:0] W_ADDR;
  logic [7:0]        W_DATA;
  logic [CNT_W-1:0]  RED_COUNT, BLUE_COUNT;

  cam_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .CAM_VSYNC(CAM_VSYNC), .CAM_HREF(CAM_HREF), .CAM_DATA(CAM_DATA),
    .W_EN(W_EN), .W_ADDR(W_ADDR), .W_DATA(W_DATA), .FRAME_DONE(FRAME_DONE),
    .RED_COUNT(RED_COUNT), .BLUE_COUNT(BLUE_COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {int cyc; int addr; int data;} wr_t;
  typedef struct {int cyc; int red; int blue;} fd_t;
  wr_t wq[$];
  fd_t dq[$];

  int total = 0, bad = 0;
  int edge_n = 0, n_wr = 0, n_done = 0, last_addr = 0, last_data = 0, max_addr = 0;
  int e_addr = 0, e_data = 0, e_red = 0, e_blue = 0;
  bit armed, cap, pvs, phr;
  int ly, bidx, mred, mblue;
  logic [7:0] mhi;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @edge %0d", tag, got, exp, edge_n);
    end
  endtask

  // Frame-level model: pixels are numbered per line from byte pairs, lines counted from HREF
  // falls; anything at or past the image edge is dropped.
  task automatic model_step(input bit vs, input bit hr, input logic [7:0] d, input int cyc);
    logic [7:0] p;
    int px;
    if (RESET) begin
      armed = 0; cap = 0; pvs = 0; phr = 0;
      return;
    end
    if (!cap) begin
      if (armed && pvs && !vs) begin
        cap = 1; ly = 0; bidx = 0; mred = 0; mblue = 0;
      end else if (vs) armed = 1;
    end else begin
      if (hr) begin
        if (bidx % 2 == 0) mhi = d;
        else begin
          px = bidx / 2;
          if (px < IMG_W && ly < IMG_H) begin
            p = {mhi[7:5], mhi[2:0], d[4:3]};
            wq.push_back('{cyc, ly * IMG_W + px, int'(p)});
            if (p[7:5] >= 5 && p[1:0] <= 1 && mred < 65535) mred++;
            if (p[1:0] >= 2 && p[7:5] <= 2 && mblue < 65535) mblue++;
          end
        end
        bidx++;
      end else if (phr) begin
        ly++; bidx = 0;
      end
      if (vs && !pvs) begin
        dq.push_back('{cyc, mred, mblue});
        cap = 0;
      end
    end
    pvs = vs; phr = hr;
  endtask

  task automatic drive(input bit vs, input bit hr, input logic [7:0] d);
    @(negedge CLOCK);
    CAM_VSYNC = vs; CAM_HREF = hr; CAM_DATA = d;
    model_step(vs, hr, d, edge_n + 1);
  endtask

  task automatic frame_start();
    repeat (2) drive(1, 0, 8'h00);
    repeat (2) drive(0, 0, 8'h00);
  endtask

  task automatic frame_end();
    repeat (2) drive(1, 0, 8'h00);
  endtask

  task automatic gap();
    repeat (2) drive(0, 0, 8'h00);
  endtask

  initial forever begin
    bit ew, ed;
    @(posedge CLOCK);
    edge_n++;
    #1;
    if (RESET) begin
      wq.delete(); dq.delete();
      e_addr = 0; e_data = 0; e_red = 0; e_blue = 0;
    end
    ew = wq.size() > 0 && wq[0].cyc == edge_n;
    ed = dq.size() > 0 && dq[0].cyc == edge_n;
    chk("w_en", W_EN, ew);
    chk("frame_done", FRAME_DONE, ed);
    if (W_EN) begin
      n_wr++;
      last_addr = int'(W_ADDR);
      last_data = int'(W_DATA);
      if (int'(W_ADDR) > max_addr) max_addr = int'(W_ADDR);
    end
    if (FRAME_DONE) n_done++;
    if (ew) begin e_addr = wq[0].addr; e_data = wq[0].data; end
    if (ed) begin e_red = dq[0].red; e_blue = dq[0].blue; end
    while (wq.size() > 0 && wq[0].cyc <= edge_n) void'(wq.pop_front());
    while (dq.size() > 0 && dq[0].cyc <= edge_n) void'(dq.pop_front());
    chk("w_addr", W_ADDR, e_addr);
    chk("w_data", W_DATA, e_data);
    chk("red_count", RED_COUNT, e_red);
    chk("blue_count", BLUE_COUNT, e_blue);
  end

  initial begin
    int w0, d0, nl, nb;
    RESET = 1'b1; CAM_VSYNC = 1'b0; CAM_HREF = 1'b0; CAM_DATA = 8'h00;
    repeat (3) drive(0, 0, 8'h00);
    chk("rst_w_en", W_EN, 0);
    chk("rst_w_addr", W_ADDR, 0);
    chk("rst_red", RED_COUNT, 0);
    // Reset released in the middle of an active line: nothing may be written.
    repeat (3) drive(0, 1, 8'($urandom));
    RESET = 1'b0;
    repeat (6) drive(0, 1, 8'($urandom));
    drive(0, 0, 8'h00);
    chk("no_wr_before_vs", n_wr, 0);
    // Two pixels: red then blue.
    frame_start();
    drive(0, 1, 8'hE0); drive(0, 1, 8'h00); drive(0, 1, 8'h00); drive(0, 1, 8'h18);
    gap();
    chk("two_px_count", n_wr, 2);
    chk("two_px_addr", last_addr, 1);
    chk("two_px_data", last_data, 8'h03);
    frame_end();
    chk("two_px_done", n_done, 1);
    chk("two_px_red", RED_COUNT, 1);
    chk("two_px_blue", BLUE_COUNT, 1);
    // Odd byte count: trailing byte dropped, next line starts at x=0.
    w0 = n_wr;
    frame_start();
    repeat (5) drive(0, 1, 8'($urandom));
    gap();
    drive(0, 1, 8'($urandom)); drive(0, 1, 8'($urandom));
    gap();
    frame_end();
    chk("odd_count", n_wr - w0, 3);
    chk("odd_next_line", last_addr, IMG_W);
    // VSYNC rises with the second byte of a red pixel.
    d0 = n_done;
    frame_start();
    drive(0, 1, 8'hF8); drive(1, 1, 8'h00);
    frame_end();
    chk("vs_px_done", n_done - d0, 1);
    chk("vs_px_data", last_data, 8'hE0);
    chk("vs_px_red", RED_COUNT, 1);
    // Oversized frame of pure red: only the 176x144 window is stored.
    w0 = n_wr; d0 = n_done;
    frame_start();
    for (int l = 0; l < 150; l++) begin
      for (int p = 0; p < 200; p++) begin drive(0, 1, 8'hF8); drive(0, 1, 8'h00); end
      gap();
    end
    frame_end();
    chk("full_count", n_wr - w0, IMG_W * IMG_H);
    chk("full_last_addr", last_addr, IMG_W * IMG_H - 1);
    chk("full_max_addr", max_addr, IMG_W * IMG_H - 1);
    chk("full_done", n_done - d0, 1);
    chk("full_red", RED_COUNT, IMG_W * IMG_H);
    chk("full_blue", BLUE_COUNT, 0);
    // Random small frames with random line lengths and frame-end placement.
    repeat (6) begin
      frame_start();
      nl = $urandom_range(1, 5);
      for (int l = 0; l < nl; l++) begin
        nb = $urandom_range(0, 13);
        for (int b = 0; b < nb; b++) drive(0, 1, 8'($urandom));
        repeat ($urandom_range(1, 3)) drive(0, 0, 8'($urandom));
      end
      case ($urandom_range(0, 2))
        0: begin drive(0, 1, 8'($urandom)); drive(1, 1, 8'($urandom)); end
        1: drive(1, 1, 8'($urandom));
        default: ;
      endcase
      frame_end();
    end
    // Reset in the middle of a frame clears everything and blocks writes until a new frame.
    frame_start();
    repeat (4) begin drive(0, 1, 8'hF8); drive(0, 1, 8'h00); end
    gap();
    drive(0, 1, 8'hF8);
    RESET = 1'b1;
    repeat (2) drive(0, 1, 8'($urandom));
    RESET = 1'b0;
    chk("midrst_red", RED_COUNT, 0);
    chk("midrst_w_en", W_EN, 0);
    w0 = n_wr;
    repeat (8) drive(0, 1, 8'($urandom));
    gap();
    chk("midrst_no_wr", n_wr - w0, 0);
    repeat (4) drive(0, 0, 8'h00);
    chk("wq_empty", wq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
